// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time instruction memory loader. Receives a byte stream
//               (length, little-endian payload words, XOR checksum), writes
//               each word through a single-cycle write port and holds the
//               core in reset until the image is loaded and verified.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    // Word index width; at least one bit so a single-word memory still works.
    localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_depth = 32'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CHK  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_byte_cnt;
    logic [31:0]        r_len;
    logic [31:0]        r_word_buf;
    logic [IDX_W-1:0]   r_word_idx;
    logic [7:0]         r_xor;
    logic               r_mem_we;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic               r_cpu_rst;
    logic               r_done;
    logic               r_err;

    logic               w_accept;
    logic               w_last_byte;
    logic [31:0]        w_len_full;
    logic [31:0]        w_word_full;
    logic               w_last_word;
    logic [31:0]        w_word_addr;

    // Handshake: ready only in the receiving states and never during a start pulse.
    always_comb begin
        in_ready = 1'b0;
        if (!start) begin
            in_ready = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CHK);
        end
    end

    assign w_accept    = in_valid & in_ready;
    assign w_last_byte = (r_byte_cnt == 2'd3);
    // The incoming byte completes the upper lane of either the length or the word.
    assign w_len_full  = {in_data, r_len[31:8]};
    assign w_word_full = {in_data, r_word_buf[31:8]};
    // r_len is nonzero whenever S_DATA is active, so r_len-1 does not underflow there.
    assign w_last_word = ({{(32-IDX_W){1'b0}}, r_word_idx} == (r_len - 32'd1));
    assign w_word_addr = BASE_ADDR + {{(30-IDX_W){1'b0}}, r_word_idx, 2'b00};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start overrides everything and re-arms to S_LEN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_LEN: begin
                if (w_accept && w_last_byte) begin
                    if (w_len_full > c_depth) begin
                        w_state_next = S_ERR;
                    end else if (w_len_full == 32'd0) begin
                        w_state_next = S_CHK;
                    end else begin
                        w_state_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_accept && w_last_byte && w_last_word) begin
                    w_state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (w_accept) begin
                    w_state_next = (in_data == r_xor) ? S_DONE : S_ERR;
                end
            end
            S_DONE:  w_state_next = S_DONE;
            S_ERR:   w_state_next = S_ERR;
            default: w_state_next = S_ERR;
        endcase
        if (start) begin
            w_state_next = S_LEN;
        end
    end

    // Datapath: byte assembly, checksum, write port and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt  <= 2'd0;
            r_len       <= 32'd0;
            r_word_buf  <= 32'd0;
            r_word_idx  <= '0;
            r_xor       <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_we  <= 1'b0;
            r_done    <= (w_state_next == S_DONE);
            r_err     <= (w_state_next == S_ERR);
            r_cpu_rst <= (w_state_next != S_DONE);
            if (start) begin
                r_byte_cnt <= 2'd0;
                r_len      <= 32'd0;
                r_word_buf <= 32'd0;
                r_word_idx <= '0;
                r_xor      <= 8'd0;
            end else if (w_accept) begin
                case (r_state)
                    S_LEN: begin
                        r_len      <= w_len_full;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                    S_DATA: begin
                        r_word_buf <= w_word_full;
                        r_xor      <= r_xor ^ in_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_last_byte) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= w_word_addr;
                            r_mem_wdata <= w_word_full;
                            // Hold the index on the final word so it stays in range.
                            if (!w_last_word) begin
                                r_word_idx <= r_word_idx + 1'b1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Scoreboard bench for imem_loader. Expected writes are queued
//               as bytes are issued; a monitor pops them on every mem_we.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    bit gap_mode = 1'b0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    imem_loader #(
        .DEPTH_WORDS (256),
        .BASE_ADDR   (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare every write against the scoreboard and enforce single-cycle pulses.
    initial begin
        logic prev_we;
        prev_we = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && mem_we) begin
                checks++;
                if (prev_we) begin
                    failures++;
                    $display("FAIL we_pulse: mem_we high two cycles in a row at addr 0x%08h", mem_addr);
                end
                if (exp_addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, none required", mem_addr, mem_wdata);
                end else begin
                    logic [31:0] ea;
                    logic [31:0] ed;
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    checks++;
                    if (mem_addr !== ea || mem_wdata !== ed) begin
                        failures++;
                        $display("FAIL write: got (0x%08h,0x%08h) expected (0x%08h,0x%08h)",
                                 mem_addr, mem_wdata, ea, ed);
                    end
                end
            end
            prev_we = mem_we;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready) begin
            if (n > 50) begin
                failures++;
                checks++;
                $display("FAIL ready_timeout: in_ready stuck at 0 for byte 0x%02h", b);
                in_valid = 1'b0;
                return;
            end
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (gap_mode) begin
            @(negedge clk);
        end
    endtask

    task automatic send_len(input logic [31:0] n);
        for (int i = 0; i < 4; i++) begin
            send_byte(n[8*i +: 8]);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr);
        exp_addr_q.push_back(addr);
        exp_data_q.push_back(w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic send_img1(input logic [7:0] chk);
        send_len(32'd2);
        send_word(32'h0000_0013, 32'h0);
        send_word(32'h00A0_0093, 32'h4);
        send_byte(chk);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Status right after the deciding byte (1-cycle latency) plus scoreboard drained.
    task automatic check_status(input string tag, input logic e_done, input logic e_err);
        @(negedge clk);
        check({tag, "_done"},    {31'd0, done},     {31'd0, e_done});
        check({tag, "_err"},     {31'd0, err},      {31'd0, e_err});
        check({tag, "_cpu_rst"}, {31'd0, cpu_rst},  {31'd0, !e_done});
        check({tag, "_ready"},   {31'd0, in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check({tag, "_pending"}, exp_addr_q.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mem_we",    {31'd0, mem_we},  32'd0);
        check("rst_mem_addr",  mem_addr,         32'd0);
        check("rst_mem_wdata", mem_wdata,        32'd0);
        check("rst_cpu_rst",   {31'd0, cpu_rst}, 32'd1);
        check("rst_done",      {31'd0, done},    32'd0);
        check("rst_err",       {31'd0, err},     32'd0);
        check("rst_ready",     {31'd0, in_ready}, 32'd1);

        // 1: good image
        send_img1(8'h20);
        check_status("t1", 1'b1, 1'b0);

        // 2: bad checksum
        pulse_start();
        check("start_done",    {31'd0, done},    32'd0);
        check("start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        send_img1(8'h21);
        check_status("t2", 1'b0, 1'b1);

        // 3: oversize length rejected after the 4th length byte
        pulse_start();
        check("start_err", {31'd0, err}, 32'd0);
        send_len(32'h0000_0101);
        check_status("t3", 1'b0, 1'b1);

        // 4: empty image, good and bad checksum
        pulse_start();
        send_len(32'd0);
        send_byte(8'h00);
        check_status("t4a", 1'b1, 1'b0);
        pulse_start();
        send_len(32'd0);
        send_byte(8'h01);
        check_status("t4b", 1'b0, 1'b1);

        // 5: in_valid toggling every cycle
        pulse_start();
        gap_mode = 1'b1;
        send_img1(8'h20);
        gap_mode = 1'b0;
        check_status("t5", 1'b1, 1'b0);

        // 6: abort mid-word, byte offered with start is dropped, then full image
        pulse_start();
        send_len(32'd2);
        send_byte(8'h13);
        send_byte(8'h00);
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        #1;
        check("t6_ready_in_start", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        send_img1(8'h20);
        check_status("t6", 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
